// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU results and FIFO-buffered LSU results onto the single regfile write port
module regfile_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alu_valid_i,
    output logic                       alu_ready_o,
    input  logic [4:0]                 alu_rd_addr_i,
    input  logic [31:0]                alu_rd_data_i,
    input  logic                       lsu_valid_i,
    output logic                       lsu_ready_o,
    input  logic [4:0]                 lsu_rd_addr_i,
    input  logic [31:0]                lsu_rd_data_i,
    input  logic [4:0]                 chk_addr_i,
    output logic                       chk_hit_o,
    output logic                       rd_wren,
    output logic [4:0]                 rd_addr,
    output logic [31:0]                rd_data,
    output logic [$clog2(DEPTH):0]     fifo_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1) + 1;

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, off;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    logic          not_empty, starving, push, pop, grant_alu, fifo_hit;
    logic [4:0]    g_addr;
    logic [31:0]   g_data;

    assign not_empty    = count != '0;
    assign starving     = not_empty && (starve_cnt >= SW'(STARVE_MAX));
    assign grant_alu    = !starving && alu_valid_i;
    // pop is decided from registered count only, so a same-cycle push never falls through
    assign pop          = starving || (!alu_valid_i && not_empty);
    assign lsu_ready_o  = count < CW'(DEPTH);
    assign push         = lsu_valid_i && lsu_ready_o;
    assign alu_ready_o  = !starving;
    assign fifo_count_o = count;
    assign g_addr       = pop ? mem_addr[rd_ptr] : alu_rd_addr_i;
    assign g_data       = pop ? mem_data[rd_ptr] : alu_rd_data_i;

    always_comb begin
        fifo_hit = 1'b0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (({1'b0, off} < count) && (mem_addr[i] == chk_addr_i))
                fifo_hit = 1'b1;
        end
        chk_hit_o = (chk_addr_i != '0) && (fifo_hit || (rd_wren && rd_addr == chk_addr_i));
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr[wr_ptr] <= lsu_rd_addr_i;
            mem_data[wr_ptr] <= lsu_rd_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            rd_wren    <= 1'b0;
            rd_addr    <= '0;
            rd_data    <= '0;
        end else begin
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count      <= count + CW'(push) - CW'(pop);
            starve_cnt <= (!not_empty || pop) ? '0 :
                          (starve_cnt >= SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
            rd_wren    <= (pop || grant_alu) && (g_addr != '0);
            if (pop || grant_alu) begin
                rd_addr <= g_addr;
                rd_data <= g_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_addr = '0;
    logic [31:0] lsu_data = '0;
    logic [4:0]  chk_addr = '0;
    logic        chk_hit;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  fifo_count;
    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.DEPTH(2), .STARVE_MAX(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready),
        .alu_rd_addr_i(alu_addr), .alu_rd_data_i(alu_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
        .lsu_rd_addr_i(lsu_addr), .lsu_rd_data_i(lsu_data),
        .chk_addr_i(chk_addr), .chk_hit_o(chk_hit),
        .rd_wren(rd_wren), .rd_addr(rd_addr), .rd_data(rd_data),
        .fifo_count_o(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset then idle
        tick();
        tick();
        rst = 1'b0;
        chk_addr = 5'd5;
        #1;
        chk("rst_wren", 32'(rd_wren), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_hit", 32'(chk_hit), 32'd0);
        // ALU only
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h13579bdf;
        #1;
        chk("alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0; chk_addr = 5'd3;
        chk("alu_wren", 32'(rd_wren), 32'd1);
        chk("alu_addr", 32'(rd_addr), 32'd3);
        chk("alu_data", rd_data, 32'h13579bdf);
        #1;
        chk("alu_hit_out_reg", 32'(chk_hit), 32'd1);
        tick();
        chk("alu_wren_off", 32'(rd_wren), 32'd0);
        chk("alu_addr_hold", 32'(rd_addr), 32'd3);
        // LSU only, x0 filtered
        lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h1;
        tick();
        lsu_addr = 5'd0; lsu_data = 32'hdead;
        chk("lsu_wren_n1", 32'(rd_wren), 32'd0);
        chk("lsu_count1", 32'(fifo_count), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("lsu_wren", 32'(rd_wren), 32'd1);
        chk("lsu_addr", 32'(rd_addr), 32'd4);
        chk("lsu_data", rd_data, 32'h1);
        chk("lsu_count_x0", 32'(fifo_count), 32'd1);
        tick();
        chk("x0_wren", 32'(rd_wren), 32'd0);
        chk("x0_data", rd_data, 32'hdead);
        chk("x0_count", 32'(fifo_count), 32'd0);
        tick();
        // starvation
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h55;
        lsu_valid = 1'b1; lsu_addr = 5'd8; lsu_data = 32'h246;
        #1;
        chk("stv_ready_c0", 32'(alu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("stv_count", 32'(fifo_count), 32'd1);
        chk("stv_alu_addr", 32'(rd_addr), 32'd5);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("stv_ready_c%0d", i), 32'(alu_ready), 32'd1);
            tick();
        end
        chk("stv_ready_drop", 32'(alu_ready), 32'd0);
        tick();
        chk("stv_head_addr", 32'(rd_addr), 32'd8);
        chk("stv_head_data", rd_data, 32'h246);
        chk("stv_head_wren", 32'(rd_wren), 32'd1);
        chk("stv_ready_back", 32'(alu_ready), 32'd1);
        tick();
        chk("stv_alu_resume", 32'(rd_addr), 32'd5);
        chk("stv_alu_resume_data", rd_data, 32'h55);
        // full / backpressure / hazard query; entries wrap around the pointers
        lsu_valid = 1'b1; lsu_addr = 5'd12; lsu_data = 32'haaaa;
        tick();
        lsu_addr = 5'd9; lsu_data = 32'hbbbb;
        tick();
        lsu_addr = 5'd14; lsu_data = 32'hcccc; chk_addr = 5'd12;
        #1;
        chk("full_ready", 32'(lsu_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd2);
        chk("hit_12", 32'(chk_hit), 32'd1);
        chk_addr = 5'd9;
        #1;
        chk("hit_9", 32'(chk_hit), 32'd1);
        chk_addr = 5'd0;
        #1;
        chk("hit_x0", 32'(chk_hit), 32'd0);
        chk_addr = 5'd14;
        #1;
        chk("hit_held_beat", 32'(chk_hit), 32'd0);
        tick();
        tick();
        tick();
        chk("full_pop12_addr", 32'(rd_addr), 32'd12);
        chk("full_pop12_data", rd_data, 32'haaaa);
        chk("full_count_after", 32'(fifo_count), 32'd1);
        chk("full_ready_after", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        chk("held_pushed_count", 32'(fifo_count), 32'd2);
        chk("held_alu_addr", 32'(rd_addr), 32'd5);
        tick();
        chk("drain_9", 32'(rd_addr), 32'd9);
        chk("drain_9_data", rd_data, 32'hbbbb);
        tick();
        chk("drain_14", 32'(rd_addr), 32'd14);
        chk("drain_14_data", rd_data, 32'hcccc);
        chk("drain_count", 32'(fifo_count), 32'd0);
        tick();
        // reset mid-operation
        alu_valid = 1'b1; alu_addr = 5'd5;
        lsu_valid = 1'b1; lsu_addr = 5'd20; lsu_data = 32'h2020;
        tick();
        lsu_addr = 5'd21; lsu_data = 32'h2121;
        tick();
        chk("pre_rst_count", 32'(fifo_count), 32'd2);
        lsu_valid = 1'b0; alu_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; chk_addr = 5'd20;
        #1;
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_wren", 32'(rd_wren), 32'd0);
        chk("mid_rst_hit", 32'(chk_hit), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("flushed_no_write%0d", i), 32'(rd_wren), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
